color_centroid: RTL and testbench

- Per-colour centre-of-mass stage. Its outputs feed the vectors stage as red/purple/green/blue x_com, y_com and valid; one instance is built per tracked colour.
- Accumulates the coordinates of mask-qualified pixels over one frame.
- On a frame-end strobe, divides the sums by the pixel count with an iterative divider.
- Presents an 11-bit x / 10-bit y centroid with a one-cycle valid pulse.

---
 rtl/centroid_pkg.sv | 18 +
 rtl/color_centroid_iter_divider.sv | 65 ++++++
 rtl/color_centroid.sv | 129 ++++++++++++
 tb/tb_color_centroid.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared widths, FSM state and coordinate types for the colour-tracking pipeline.
package centroid_pkg;

    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned SUM_W = 32;
    localparam int unsigned CNT_W = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    typedef logic [X_W-1:0] x_coord_t;
    typedef logic [Y_W-1:0] y_coord_t;

endpackage

// File: rtl/color_centroid_iter_divider.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the start edge.
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_src, quo_src, div_src;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // One restoring step, sourced from the fresh operands on start or the running state otherwise.
    always_comb begin
        rem_src = start ? '0 : remainder;
        quo_src = start ? dividend : quotient;
        div_src = start ? divisor : div_q;
        shifted = {rem_src, quo_src[WIDTH-1]};
        fits    = (shifted >= {1'b0, div_src});
        rem_n   = fits ? WIDTH'(shifted - {1'b0, div_src}) : shifted[WIDTH-1:0];
        quo_n   = {quo_src[WIDTH-2:0], fits};
    end

    // Iteration registers: start performs step 1, the remaining WIDTH-1 steps follow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remainder <= '0;
            quotient  <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            remainder <= rem_n;
            quotient  <= quo_n;
            div_q     <= divisor;
            cnt_q     <= CW'(WIDTH - 1);
            busy      <= 1'b1;
            done      <= 1'b0;
        end else if (busy) begin
            remainder <= rem_n;
            quotient  <= quo_n;
            cnt_q     <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/color_centroid.sv
// Per-colour centre of mass: accumulate masked pixel coordinates, divide at frame end, publish.
module color_centroid
    import centroid_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned V_ACTIVE   = 720,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic           valid_in,
    input  logic           tabulate_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           valid_out,
    output logic           busy_out
);

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_x, sum_y;
    logic [CNT_W-1:0]   cnt;
    logic               tab_take, start, publish;
    logic [SUM_W-1:0]   quo_x, quo_y, rem_x, rem_y;
    logic               done_x, done_y, busy_x, busy_y;
    x_coord_t           x_res;
    y_coord_t           y_res;
    logic               unused_div;

    assign unused_div = ^{rem_x, rem_y, done_y, busy_x, busy_y};

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle strobes.
    always_comb begin
        state_d  = state_q;
        tab_take = 1'b0;
        start    = 1'b0;
        publish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tabulate_in) begin
                    tab_take = 1'b1;
                    if (cnt >= CNT_W'(MIN_PIXELS)) begin
                        start   = 1'b1;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE:  if (done_x) state_d = PUBLISH;
            PUBLISH: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame accumulators; an honoured tabulate restarts them, keeping a coincident pixel.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_x <= '0;
            sum_y <= '0;
            cnt   <= '0;
        end else if (tab_take) begin
            sum_x <= valid_in ? SUM_W'(x_in) : '0;
            sum_y <= valid_in ? SUM_W'(y_in) : '0;
            cnt   <= valid_in ? CNT_W'(1) : '0;
        end else if (valid_in) begin
            sum_x <= sum_x + SUM_W'(x_in);
            sum_y <= sum_y + SUM_W'(y_in);
            cnt   <= cnt + CNT_W'(1);
        end
    end

    iter_divider #(.WIDTH(SUM_W)) u_div_x (
        .clk       (clk_in),
        .rst       (rst_in),
        .start     (start),
        .dividend  (sum_x),
        .divisor   (SUM_W'(cnt)),
        .quotient  (quo_x),
        .remainder (rem_x),
        .done      (done_x),
        .busy      (busy_x)
    );

    iter_divider #(.WIDTH(SUM_W)) u_div_y (
        .clk       (clk_in),
        .rst       (rst_in),
        .start     (start),
        .dividend  (sum_y),
        .divisor   (SUM_W'(cnt)),
        .quotient  (quo_y),
        .remainder (rem_y),
        .done      (done_y),
        .busy      (busy_y)
    );

    // Quotient to coordinate; the clamp only guards against out-of-range pixel input.
    always_comb begin
        x_res = (quo_x >= SUM_W'(H_ACTIVE)) ? X_W'(H_ACTIVE - 1) : X_W'(quo_x);
        y_res = (quo_y >= SUM_W'(V_ACTIVE)) ? Y_W'(V_ACTIVE - 1) : Y_W'(quo_y);
    end

    // Registered outputs: busy spans the division, results and valid land in PUBLISH.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_out     <= '0;
            y_out     <= '0;
            valid_out <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            valid_out <= publish;
            if (start)        busy_out <= 1'b1;
            else if (publish) busy_out <= 1'b0;
            if (publish) begin
                x_out <= x_res;
                y_out <= y_res;
            end
        end
    end

endmodule

// File: tb/tb_color_centroid.sv
// Scoreboard bench: two instances (MIN_PIXELS 16 and 1) share stimulus; a frame-level model predicts results.
module tb_color_centroid;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in, tabulate_in;
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;
    logic        v0, v1, b0, b1;

    always #5 clk = ~clk;

    color_centroid #(.H_ACTIVE(1280), .V_ACTIVE(720), .MIN_PIXELS(16)) dut (
        .clk_in(clk), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .tabulate_in(tabulate_in),
        .x_out(x0), .y_out(y0), .valid_out(v0), .busy_out(b0));

    color_centroid #(.H_ACTIVE(1280), .V_ACTIVE(720), .MIN_PIXELS(1)) dut1 (
        .clk_in(clk), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
        .valid_in(valid_in), .tabulate_in(tabulate_in),
        .x_out(x1), .y_out(y1), .valid_out(v1), .busy_out(b1));

    typedef struct {
        int     inst;
        int     x;
        int     y;
        longint due;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    longint edge_n = 0;

    longint m_sx[2], m_sy[2], m_cnt[2], m_next_ok[2];
    int     min_px[2];
    int     last_x[2], last_y[2];
    bit     prev_v[2];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            m_sx[i] = 0; m_sy[i] = 0; m_cnt[i] = 0; m_next_ok[i] = 0;
            last_x[i] = 0; last_y[i] = 0; prev_v[i] = 1'b0;
        end
    endtask

    // Present one cycle of input and advance the frame model for the edge that will sample it.
    task automatic drive(input int x, input int y, input bit v, input bit t);
        longint e;
        exp_t   ex;
        @(negedge clk);
        x_in = 11'(x); y_in = 10'(y); valid_in = v; tabulate_in = t;
        e = edge_n + 1;
        for (int i = 0; i < 2; i++) begin
            if (t && e >= m_next_ok[i]) begin
                if (m_cnt[i] >= min_px[i]) begin
                    ex.inst = i;
                    ex.x    = int'(m_sx[i] / m_cnt[i]);
                    ex.y    = int'(m_sy[i] / m_cnt[i]);
                    ex.due  = e + 33;
                    sb.push_back(ex);
                    m_next_ok[i] = e + 34;
                end
                m_sx[i]  = v ? x : 0;
                m_sy[i]  = v ? y : 0;
                m_cnt[i] = v ? 1 : 0;
            end else if (v) begin
                m_sx[i]  += x;
                m_sy[i]  += y;
                m_cnt[i] += 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: pop the expected result whenever an instance pulses valid_out.
    task automatic check_inst(input int i, input logic v, input logic [10:0] x, input logic [9:0] y);
        int idx;
        idx = -1;
        foreach (sb[k]) if (idx < 0 && sb[k].inst == i) idx = k;
        if (v) begin
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL unexpected_valid inst=%0d got x=%0d y=%0d", i, x, y);
            end else begin
                checks++;
                if (int'(x) != sb[idx].x || int'(y) != sb[idx].y || edge_n != sb[idx].due) begin
                    errors++;
                    $display("FAIL centroid inst=%0d got x=%0d y=%0d edge=%0d expected x=%0d y=%0d edge=%0d",
                             i, x, y, edge_n, sb[idx].x, sb[idx].y, sb[idx].due);
                end
                last_x[i] = sb[idx].x;
                last_y[i] = sb[idx].y;
                sb.delete(idx);
            end
            checks++;
            if (prev_v[i]) begin
                errors++;
                $display("FAIL double_valid inst=%0d got=1 expected=0", i);
            end
        end else begin
            if (idx >= 0 && sb[idx].due < edge_n) begin
                checks++;
                errors++;
                $display("FAIL missing_valid inst=%0d expected x=%0d y=%0d at edge=%0d",
                         i, sb[idx].x, sb[idx].y, sb[idx].due);
                sb.delete(idx);
            end
            checks++;
            if (int'(x) != last_x[i] || int'(y) != last_y[i]) begin
                errors++;
                $display("FAIL hold inst=%0d got x=%0d y=%0d expected x=%0d y=%0d",
                         i, x, y, last_x[i], last_y[i]);
            end
        end
        prev_v[i] = v;
    endtask

    always @(negedge clk) begin
        if (!rst_in) begin
            check_inst(0, v0, x0, y0);
            check_inst(1, v1, x1, y1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_x0"}, int'(x0), 0);
        check_val({tag, "_y0"}, int'(y0), 0);
        check_val({tag, "_busy0"}, int'(b0), 0);
        check_val({tag, "_valid0"}, int'(v0), 0);
        check_val({tag, "_x1"}, int'(x1), 0);
        check_val({tag, "_busy1"}, int'(b1), 0);
    endtask

    task automatic random_frame(input int n);
        for (int k = 0; k < n; k++)
            drive(int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        min_px[0] = 16;
        min_px[1] = 1;
        rst_in = 1'b1; x_in = '0; y_in = '0; valid_in = 1'b0; tabulate_in = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_in = 1'b0;

        // Single pixel: only the MIN_PIXELS=1 instance publishes.
        drive(111, 333, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        idle(40);

        // 10x10 block.
        for (int yy = 200; yy < 210; yy++)
            for (int xx = 300; xx < 310; xx++)
                drive(xx, yy, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0);
        check_val("busy_after_tab", int'(b0), 1);
        idle(40);
        check_val("busy_done", int'(b0), 0);

        // Empty frame, then 15 pixels: the MIN_PIXELS=16 instance must hold 304/204.
        drive(0, 0, 1'b0, 1'b1);
        idle(5);
        for (int k = 0; k < 15; k++) drive(10 + k, 20 + k, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        idle(40);
        check_val("hold_x", int'(x0), 304);
        check_val("hold_y", int'(y0), 204);

        // Ignored tabulate mid-divide, then pixel coincident with an honoured tabulate.
        random_frame(60);
        drive(0, 0, 1'b0, 1'b1);
        random_frame(9);
        drive(700, 500, 1'b1, 1'b1);
        random_frame(40);
        drive(5, 7, 1'b1, 1'b1);
        random_frame(30);
        drive(0, 0, 1'b0, 1'b1);
        idle(40);

        // Randomized frames, including back-to-back at the minimum gap.
        for (int f = 0; f < 6; f++) begin
            random_frame(int'($urandom_range(34, 150)));
            drive(int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), 1'($urandom_range(0, 1)), 1'b1);
        end
        idle(40);

        // Full-width lines spread over the frame height, extreme coordinates included.
        for (int r = 0; r < 20; r++)
            for (int xx = 0; xx < 1280; xx++)
                drive(xx, (r == 19) ? 719 : r * 37, 1'b1, 1'b0);
        drive(1279, 719, 1'b1, 1'b1);
        idle(40);

        // Reset mid-division: abandon it, then compute the next frame cleanly.
        random_frame(50);
        drive(0, 0, 1'b0, 1'b1);
        idle(10);
        #2;
        rst_in = 1'b1; valid_in = 1'b0; tabulate_in = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        random_frame(80);
        drive(0, 0, 1'b0, 1'b1);
        idle(50);

        foreach (sb[k]) begin
            checks++;
            errors++;
            $display("FAIL never_published inst=%0d expected x=%0d y=%0d", sb[k].inst, sb[k].x, sb[k].y);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
